// File: rtl/mul_add_seq_pkg.sv
// Shared definitions for the iterative arithmetic blocks (multiplier and divider).
package mul_add_seq_pkg;

   // One state type shared by the iterative units, so upstream control can
   // treat the divider and the multiplier the same way.
   typedef enum logic {
      IDLE = 1'b0,
      LOOP = 1'b1
   } iter_state_e;

   // Width of the iteration counter, which holds N-1 down to 0.
   // It is never narrower than one bit.
   function automatic int cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mul_add_seq_if.sv
// Operand/result handshake bundle for the shift-and-add multiplier.
interface mul_add_seq_if #(
   parameter int N_BITS = 8
);
   logic [N_BITS-1:0]   a;
   logic [N_BITS-1:0]   b;
   logic [N_BITS-1:0]   c;
   logic                start;
   logic                busy;
   logic [2*N_BITS-1:0] product;
   logic                overflow;
   logic                result_valid;

   // Requester side: drives operands and start, observes status and result.
   modport master (
      output a, b, c, start,
      input  busy, product, overflow, result_valid
   );

   // Arithmetic unit side.
   modport slave (
      input  a, b, c, start,
      output busy, product, overflow, result_valid
   );
endinterface

// File: rtl/mul_add_seq.sv
// Iterative unsigned multiply-add: product = a*b + c.
// One multiplier bit is consumed per cycle, so a result takes N_BITS cycles.
module mul_add_seq
   import mul_add_seq_pkg::*;
#(
   parameter int N_BITS = 8
) (
   input  logic        clk,
   input  logic        rst,
   mul_add_seq_if.slave bus
);

   localparam int W2 = 2 * N_BITS;
   localparam int CW = cnt_width(N_BITS);

   iter_state_e     state_q,  state_d;
   logic [W2-1:0]   a_q,      a_d;      // multiplicand, shifted left each step
   logic [N_BITS-1:0] b_q,    b_d;      // multiplier, shifted right each step
   logic [W2-1:0]   acc_q,    acc_d;    // running sum, seeded with the addend
   logic [CW-1:0]   cnt_q,    cnt_d;    // steps remaining minus one
   logic [W2-1:0]   prod_q,   prod_d;
   logic            ovf_q,    ovf_d;
   logic            valid_q,  valid_d;
   logic [W2-1:0]   acc_sum;

   // The worst case, (2^N-1)^2 + (2^N-1), fits in 2N bits, so the
   // accumulator needs no carry-out.
   // Next-state and datapath logic for one multiply-add step.
   always_comb begin
      // NOTE: each signal gets a default first, so no path can leave it
      // unassigned and infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      acc_sum = b_q[0] ? (acc_q + a_q) : acc_q;

      case (state_q)
         IDLE: begin
            // Operands are captured only here. Later input changes cannot
            // reach an operation that is already running.
            if (bus.start) begin
               a_d     = {{N_BITS{1'b0}}, bus.a};
               b_d     = bus.b;
               acc_d   = {{N_BITS{1'b0}}, bus.c};
               cnt_d   = CW'(N_BITS - 1);
               valid_d = 1'b0;
               state_d = LOOP;
            end
         end
         LOOP: begin
            // start is ignored here. The loop always runs all N_BITS steps.
            acc_d = acc_sum;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            if (cnt_q == '0) begin
               prod_d  = acc_sum;
               ovf_d   = |acc_sum[W2-1:N_BITS];
               valid_d = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. Reset discards any in-flight result.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous. rst is seen only on a rising clk edge,
      // so it has no place in the sensitivity list.
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         prod_q  <= '0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments let every register update from
         // values sampled before the edge, whatever the statement order.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   assign bus.busy         = (state_q == LOOP);
   assign bus.product      = prod_q;
   assign bus.overflow     = ovf_q;
   assign bus.result_valid = valid_q;

endmodule

// File: tb/tb_mul_add_seq.sv
// Scoreboard bench for mul_add_seq.
// A cycle-level reference model queues the expected results, and a monitor
// checks the results as the DUT presents them.
module tb_mul_add_seq;
   import mul_add_seq_pkg::*;

   localparam int N = 8;

   typedef struct {
      logic [2*N-1:0] prod;
      logic           ovf;
      int             due;
   } exp_t;

   logic clk;
   logic rst;
   mul_add_seq_if #(.N_BITS(N)) io ();

   mul_add_seq #(.N_BITS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (io)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   n_vec;
   int   n_miss;
   int   cyc;
   int   remaining;
   int   n_accepted;
   bit   chk_reset;
   bit   started;
   exp_t sb[$];
   exp_t e;
   logic prev_valid;
   logic [2*N-1:0] last_prod;
   logic last_ovf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model.
   // An accepted start schedules the result a*b+c to land N edges later,
   // and the unit stays busy for that whole interval.
   always @(posedge clk) begin
      logic [2*N-1:0] r;
      cyc++;
      if (rst) begin
         sb.delete();
         remaining = 0;
         chk_reset = 1'b1;
         started   = 1'b1;
      end else if (remaining == 0) begin
         if (io.start) begin
            r = (2*N)'(io.a) * (2*N)'(io.b) + (2*N)'(io.c);
            sb.push_back('{prod: r, ovf: (r >= (2*N)'(1 << N)), due: cyc + N});
            remaining = N;
            n_accepted++;
         end
      end else begin
         remaining--;
      end
   end

   // Monitor: sample away from the active edge and compare with the model.
   always @(negedge clk) begin
      if (chk_reset) begin
         check("reset_busy", {31'd0, io.busy}, 0);
         check("reset_valid", {31'd0, io.result_valid}, 0);
         check("reset_product", {16'd0, io.product}, 0);
         check("reset_overflow", {31'd0, io.overflow}, 0);
         chk_reset  = 1'b0;
         prev_valid = 1'b0;
         last_prod  = '0;
         last_ovf   = 1'b0;
      end else if (started) begin
         check("busy", {31'd0, io.busy}, {31'd0, remaining != 0});
         if (remaining != 0)
            check("valid_low_while_busy", {31'd0, io.result_valid}, 0);
         if (io.result_valid && !prev_valid) begin
            check("result_expected", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("product", {16'd0, io.product}, {16'd0, e.prod});
               check("overflow", {31'd0, io.overflow}, {31'd0, e.ovf});
               check("latency_edge", cyc, e.due);
            end
            last_prod = io.product;
            last_ovf  = io.overflow;
         end else begin
            check("product_hold", {16'd0, io.product}, {16'd0, last_prod});
            check("overflow_hold", {31'd0, io.overflow}, {31'd0, last_ovf});
         end
         prev_valid = io.result_valid;
      end
   end

   // Wait, within a cycle budget, until the model reports the unit idle.
   task automatic wait_idle();
      for (int i = 0; i < 4 * N && remaining != 0; i++) @(negedge clk);
      check("idle_timeout", {31'd0, remaining != 0}, 0);
   endtask

   // Issue one operation.
   // With scramble set, the inputs change while the loop runs.
   task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [N-1:0] ic, input bit scramble);
      @(negedge clk);
      io.a = ia; io.b = ib; io.c = ic; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      for (int i = 0; i < 4 * N && remaining != 0; i++) begin
         if (scramble) begin
            io.a = N'($urandom); io.b = N'($urandom); io.c = N'($urandom);
         end
         @(negedge clk);
      end
      wait_idle();
   endtask

   initial begin
      int acc0;
      logic [N-1:0] num, den;
      n_vec = 0; n_miss = 0; cyc = 0; remaining = 0; n_accepted = 0;
      chk_reset = 1'b0; started = 1'b0; prev_valid = 1'b0;
      last_prod = '0; last_ovf = 1'b0;
      rst = 1'b1;
      io.a = '0; io.b = '0; io.c = '0; io.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Directed cases.
      issue(8'd13, 8'd11, 8'd5, 1'b0);
      check("basic_148", {16'd0, io.product}, 148);
      issue(8'd255, 8'd255, 8'd255, 1'b0);
      check("max_prod", {16'd0, io.product}, 65280);
      check("max_ovf", {31'd0, io.overflow}, 1);
      issue(8'd0, 8'd200, 8'd0, 1'b0);
      check("zero_prod", {16'd0, io.product}, 0);
      issue(8'd28, 8'd7, 8'd4, 1'b0);
      check("roundtrip_200", {16'd0, io.product}, 200);
      check("roundtrip_ovf", {31'd0, io.overflow}, 0);

      // Hold start high: three results at one per N+1 cycles.
      @(negedge clk);
      acc0 = n_accepted;
      io.a = 8'd3; io.b = 8'd4; io.c = 8'd0; io.start = 1'b1;
      for (int i = 0; i < 40 && n_accepted < acc0 + 3; i++) @(negedge clk);
      io.start = 1'b0;
      check("held_start_count", n_accepted - acc0, 3);
      wait_idle();

      // Inputs changing during the loop must not affect the result.
      issue(8'd77, 8'd91, 8'd33, 1'b1);

      // Reset sampled at edge k+4 of a 9*9 operation.
      @(negedge clk);
      io.a = 8'd9; io.b = 8'd9; io.c = 8'd0; io.start = 1'b1;
      @(negedge clk);
      io.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      issue(8'd9, 8'd9, 8'd1, 1'b0);
      check("post_reset_82", {16'd0, io.product}, 82);

      // Idle hold: the result and result_valid stay put.
      repeat (20) @(negedge clk);
      check("idle_valid", {31'd0, io.result_valid}, 1);
      check("idle_product", {16'd0, io.product}, 82);

      // Random sweep: plain operands, then divider round-trips.
      for (int i = 0; i < 15; i++)
         issue(N'($urandom), N'($urandom), N'($urandom), i[0]);
      for (int i = 0; i < 15; i++) begin
         num = N'($urandom);
         den = N'($urandom_range(1, 255));
         issue(num / den, den, num % den, 1'b0);
         check("div_roundtrip", {16'd0, io.product}, {24'd0, num});
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Iterative shift-and-add unsigned multiplier with addend. Computes product = a*b + c over N_BITS cycles.
- Inverse companion of the sequential divider: feeding it quotient, denominator and remainder reconstructs the numerator.
- Used by the graphics pipeline for coordinate scaling and for divider self-check.
- Uses the same start / busy / result_valid handshake as the divider, so the two can share control logic upstream.

Parameters:
- N_BITS, 8, operand width; product width is 2*N_BITS.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- a  input  N_BITS  multiplicand, unsigned.
- b  input  N_BITS  multiplier, unsigned.
- c  input  N_BITS  addend, unsigned, zero-extended.
- start  input  1  request; sampled only in IDLE.
- busy  output  1  high while an operation is in progress.
- product  output  2*N_BITS  a*b + c.
- overflow  output  1  high when product[2N-1:N] is nonzero, i.e. result does not fit in N_BITS.
- result_valid  output  1  product/overflow hold a completed result.

Behaviour:
- Reset: state=IDLE, busy=0, result_valid=0, product=0, overflow=0, internal registers cleared. Reset applies in any state, including mid-operation; the in-flight result is discarded.
- States: IDLE, LOOP.
- IDLE with start=1 at edge k:
  - Latch A = {N zeros, a} (2N wide), B = b, ACC = zero-extended c, counter i = N_BITS-1.
  - busy=1, result_valid=0, go to LOOP.
  - product/overflow keep their previous values until the new result lands.
- IDLE with start=0: hold. busy=0. result_valid and product keep their last values.
- LOOP, each cycle:
  - If B[0], ACC = ACC + A (2N-bit add, no carry-out possible).
  - A = A << 1; B = B >> 1.
  - If i==0: product=ACC (post-add), overflow=|ACC[2N-1:N], result_valid=1, busy=0, state=IDLE.
  - Else i = i-1.
- Latency:
  - start sampled at edge k; result_valid rises at edge k+N_BITS.
  - busy is high from edge k+1 through edge k+N_BITS-1.
  - Fixed latency; no early termination even when b=0.
- Width rule: max result (2^N-1)^2 + (2^N-1) = 2^2N - 2^N, so 2N bits is always exact.
- start while in LOOP: ignored, no queueing.
- start in the cycle after completion: accepted normally, giving back-to-back throughput of one result per N_BITS+1 cycles.
- result_valid stays high until the next accepted start or reset.
- Inputs a/b/c are only sampled at the accepting edge; later changes do not affect the in-flight result.
- Counter width is $clog2(N_BITS), minimum 1 bit. N_BITS must be at least 2.

Decomposition:
- Shared package (e.g. arith_pkg):
  - iter_state enum {IDLE, LOOP}, replacing the per-module enum so divider and mul_add_seq share one typedef with no name clash.
  - A localparam function for counter width, max(1, $clog2(N)).
- No sub-module. The datapath is one register set plus one 2N-bit adder, which stays in-module.

Test Plan (N_BITS=8):
- Basic: a=13, b=11, c=5, start pulse → result_valid at edge k+8, product=148, overflow=0; busy high on edges k+1..k+7.
- Extremes: a=255, b=255, c=255 → product=65280 (0xFF00), overflow=1. Then a=0, b=200, c=0 → product=0, overflow=0, still 8-cycle latency.
- Divider round-trip: 200/7 gives q=28, r=4; a=28, b=7, c=4 → product=200, overflow=0. Sweep random numerators/denominators through both blocks and compare.
- start held high continuously with a=3, b=4, c=0 → results 12 at edges k+8, k+17, k+26. Change a/b mid-LOOP → in-flight result unchanged.
- Reset mid-operation: assert rst at edge k+4 of a=9, b=9 → next edge busy=0, result_valid=0, product=0. A new start then yields a correct result.
- Idle hold: after a completed result, 20 cycles with start=0 → result_valid stays 1 and product is stable.
